// File: rtl/regs_dump.sv
// regs_dump: read-side master for the picoMIPS register file.
// On a start pulse it walks every register through one read port and
// streams a framed snapshot on a valid/ready byte interface:
//   header (N mod 2**DATA_WIDTH), register 0..N-1 in address order,
//   then the XOR checksum of the register words (tx_last set).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - single-cycle dump request, accepted only when idle
//   raddr/rdata - register file read port (rdata combinational from raddr)
//   tx_data/tx_valid/tx_ready/tx_last - output word stream
//   busy        - high whenever a frame is in progress
//   done        - one-cycle pulse after the checksum transfer
module regs_dump #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned N = 2 ** ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] HDR_WORD = DATA_WIDTH'(N);

  typedef enum logic [2:0] {IDLE, HDR, FETCH, SEND, CSUM} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   index, index_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic [DATA_WIDTH-1:0]   csum, csum_nxt;
  logic                    valid_nxt, last_nxt, done_nxt;
  logic                    xfer;

  assign xfer  = tx_valid & tx_ready;
  assign raddr = index;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      index    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      done     <= 1'b0;
      csum     <= '0;
    end else begin
      state    <= state_nxt;
      index    <= index_nxt;
      tx_data  <= data_nxt;
      tx_valid <= valid_nxt;
      tx_last  <= last_nxt;
      done     <= done_nxt;
      csum     <= csum_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    data_nxt  = tx_data;
    valid_nxt = tx_valid;
    last_nxt  = tx_last;
    csum_nxt  = csum;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = HDR;
          data_nxt  = HDR_WORD;
          valid_nxt = 1'b1;
          last_nxt  = 1'b0;
          index_nxt = '0;
          csum_nxt  = '0;
        end
      end
      HDR: begin
        if (xfer) begin
          state_nxt = FETCH;
          valid_nxt = 1'b0;
        end
      end
      FETCH: begin
        // rdata reflects raddr (= index) in this single cycle; sampled here.
        state_nxt = SEND;
        data_nxt  = rdata;
        csum_nxt  = csum ^ rdata;
        valid_nxt = 1'b1;
      end
      SEND: begin
        if (xfer) begin
          if (index == '1) begin
            state_nxt = CSUM;
            data_nxt  = csum;
            valid_nxt = 1'b1;
            last_nxt  = 1'b1;
          end else begin
            state_nxt = FETCH;
            index_nxt = index + ADDR_WIDTH'(1);
            valid_nxt = 1'b0;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regs_dump.sv
// Self-checking bench for regs_dump: a behavioural register file drives rdata,
// a negedge monitor records every stream transfer, and each frame is compared
// against a frame built from the register snapshot by plain arithmetic.
module tb_regs_dump;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata, tx_data;
  logic          tx_valid, tx_last, busy, done;

  logic [DW-1:0] regs [N];
  assign rdata = regs[raddr];

  always #5 clk = ~clk;

  regs_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .raddr(raddr), .rdata(rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] got_w [$];
  logic [DW-1:0] exp_w [$];
  bit            got_l [$];
  int            got_a [$];
  int            stall_viol = 0;
  int            done_cnt = 0;

  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;

  typedef struct {int cyc; int kind; int addr; logic [DW-1:0] val;} ev_t;
  ev_t evq [$];

  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && (tx_valid !== 1'b1 || tx_data !== pd || tx_last !== pl))
        stall_viol++;
      if (done === 1'b1) done_cnt++;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        got_w.push_back(tx_data);
        got_l.push_back(tx_last);
        got_a.push_back(int'(raddr));
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data; pl = tx_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c % 4) == 0) || ((c % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Reference frame: header N, the sampled register words, XOR of those words.
  function automatic void build_exp(input logic [DW-1:0] s [N]);
    logic [DW-1:0] x = '0;
    exp_w.delete();
    exp_w.push_back(DW'(N));
    for (int k = 0; k < N; k++) begin
      exp_w.push_back(s[k]);
      x = x ^ s[k];
    end
    exp_w.push_back(x);
  endfunction

  function automatic int frame_errors();
    int e = 0;
    if (got_w.size() != exp_w.size()) return 1000 + got_w.size();
    for (int i = 0; i < exp_w.size(); i++) if (got_w[i] !== exp_w[i]) e++;
    return e;
  endfunction

  function automatic int last_errors();
    int e = 0;
    if (got_l.size() != N + 2) return 1000 + got_l.size();
    for (int i = 0; i < N + 2; i++) if (got_l[i] != (i == N + 1)) e++;
    return e;
  endfunction

  // Header is sent with index 0, register k with index k, checksum with N-1.
  function automatic int addr_errors();
    int e = 0;
    int ex;
    if (got_a.size() != N + 2) return 1000 + got_a.size();
    for (int i = 0; i < N + 2; i++) begin
      ex = (i == 0) ? 0 : (i == N + 1) ? N - 1 : i - 1;
      if (got_a[i] != ex) e++;
    end
    return e;
  endfunction

  // Pulses start in the current cycle, applies queued events, returns in the done cycle.
  task automatic run_frame(input int mode, input int budget,
                           output int cycles, output bit tmo, output int busy_bad);
    busy_bad = 0;
    start = 1'b1;
    tx_ready = rdy(mode, 0);
    tick();
    start = 1'b0;
    cycles = 1;
    got_w.delete(); got_l.delete(); got_a.delete();
    stall_viol = 0;
    done_cnt = 0;
    while (done !== 1'b1 && cycles < budget) begin
      if (busy !== 1'b1) busy_bad++;
      foreach (evq[i]) begin
        if (evq[i].cyc == cycles) begin
          if (evq[i].kind == 0) regs[evq[i].addr] = evq[i].val;
          else start = 1'b1;
        end
      end
      tx_ready = rdy(mode, cycles);
      tick();
      start = 1'b0;
      cycles++;
    end
    tmo = (done !== 1'b1);
    evq.delete();
  endtask

  task automatic preset();
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h44; regs[3] = 8'h88;
  endtask

  task automatic test_reset();
    preset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({tx_valid, tx_last, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: valid/last/busy/done=%b required 0000", {tx_valid, tx_last, busy, done});
    end
    checks++;
    if (raddr !== '0) begin errors++; $display("FAIL reset_raddr: got %0d required 0", raddr); end
    checks++;
    if (tx_data !== '0) begin errors++; $display("FAIL reset_data: got %h required 00", tx_data); end
  endtask

  task automatic test_basic();
    int cyc, bb; bit tmo;
    preset();
    build_exp(regs);
    run_frame(0, 40, cyc, tmo, bb);
    checks++;
    if (tmo) begin errors++; $display("FAIL basic_timeout: done not seen after %0d cycles", cyc); end
    checks++;
    if (cyc != 11) begin errors++; $display("FAIL basic_latency: got %0d cycles required 11", cyc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: busy=%b required 0", busy); end
    repeat (2) tick();
    checks++;
    if (frame_errors() != 0) begin errors++; $display("FAIL basic_words: %0d bad positions required 0", frame_errors()); end
    checks++;
    if (last_errors() != 0) begin errors++; $display("FAIL basic_last: %0d bad positions required 0", last_errors()); end
    checks++;
    if (addr_errors() != 0) begin errors++; $display("FAIL basic_raddr: %0d bad positions required 0", addr_errors()); end
    checks++;
    if (bb != 0) begin errors++; $display("FAIL basic_busy: %0d idle cycles mid-frame required 0", bb); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulse: %0d done cycles required 1", done_cnt); end
  endtask

  task automatic test_stall();
    int cyc, bb; bit tmo;
    preset();
    build_exp(regs);
    run_frame(1, 100, cyc, tmo, bb);
    repeat (2) tick();
    checks++;
    if (tmo) begin errors++; $display("FAIL stall_timeout: done not seen after %0d cycles", cyc); end
    checks++;
    if (frame_errors() != 0) begin errors++; $display("FAIL stall_words: %0d bad positions required 0", frame_errors()); end
    checks++;
    if (last_errors() != 0) begin errors++; $display("FAIL stall_last: %0d bad positions required 0", last_errors()); end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL stall_stable: %0d unstable stall cycles required 0", stall_viol); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL stall_done_pulse: %0d done cycles required 1", done_cnt); end
  endtask

  task automatic test_zero();
    int cyc, bb; bit tmo;
    for (int k = 0; k < N; k++) regs[k] = '0;
    build_exp(regs);
    run_frame(0, 40, cyc, tmo, bb);
    repeat (2) tick();
    checks++;
    if (tmo || cyc != 11) begin errors++; $display("FAIL zero_latency: got %0d cycles (timeout=%0d) required 11", cyc, tmo); end
    checks++;
    if (frame_errors() != 0) begin errors++; $display("FAIL zero_words: %0d bad positions required 0", frame_errors()); end
    checks++;
    if (last_errors() != 0) begin errors++; $display("FAIL zero_last: %0d bad positions required 0", last_errors()); end
    checks++;
    if (bb != 0) begin errors++; $display("FAIL zero_busy: %0d idle cycles mid-frame required 0", bb); end
  endtask

  task automatic test_restart();
    int cyc, bb; bit tmo;
    preset();
    build_exp(regs);
    evq.push_back('{5, 1, 0, 8'h00});   // SEND of register 1
    evq.push_back('{10, 1, 0, 8'h00});  // final CSUM transfer cycle
    run_frame(0, 40, cyc, tmo, bb);
    checks++;
    if (tmo || cyc != 11) begin errors++; $display("FAIL restart_latency: got %0d cycles (timeout=%0d) required 11", cyc, tmo); end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL restart_idle: busy=%b valid=%b required 0 0", busy, tx_valid);
    end
    checks++;
    if (frame_errors() != 0) begin errors++; $display("FAIL restart_words: %0d bad positions required 0", frame_errors()); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL restart_done: %0d done cycles required 1", done_cnt); end
    run_frame(0, 40, cyc, tmo, bb);
    repeat (2) tick();
    checks++;
    if (tmo || frame_errors() != 0) begin errors++; $display("FAIL restart_second: %0d bad positions (timeout=%0d) required 0", frame_errors(), tmo); end
  endtask

  task automatic test_back_to_back();
    int cyc, bb; bit tmo;
    preset();
    run_frame(0, 40, cyc, tmo, bb);
    regs[1] = 8'h3C;
    build_exp(regs);
    run_frame(0, 40, cyc, tmo, bb);  // start lands in the done cycle
    repeat (2) tick();
    checks++;
    if (tmo || cyc != 11) begin errors++; $display("FAIL b2b_latency: got %0d cycles (timeout=%0d) required 11", cyc, tmo); end
    checks++;
    if (frame_errors() != 0) begin errors++; $display("FAIL b2b_words: %0d bad positions required 0", frame_errors()); end
  endtask

  task automatic test_snapshot();
    int cyc, bb; bit tmo;
    logic [DW-1:0] snap [N];
    preset();
    snap[0] = 8'h11; snap[1] = 8'h22; snap[2] = 8'h5A; snap[3] = 8'h88;
    build_exp(snap);
    evq.push_back('{3, 0, 2, 8'h5A});  // before register 2 is fetched
    evq.push_back('{4, 0, 0, 8'hA5});  // after register 0 is fetched
    run_frame(0, 40, cyc, tmo, bb);
    repeat (2) tick();
    checks++;
    if (frame_errors() != 0) begin errors++; $display("FAIL snap_words: %0d bad positions required 0", frame_errors()); end
    checks++;
    if (got_w.size() != N + 2 || got_w[N + 1] !== 8'hE1) begin
      errors++; $display("FAIL snap_csum: got %h (%0d words) required e1", (got_w.size() > 0) ? got_w[got_w.size() - 1] : 8'h00, got_w.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bb; bit tmo;
    preset();
    start = 1'b1;
    tx_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();  // now in cycle t+7: SEND of register 2
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h44) begin
      errors++; $display("FAIL midrst_setup: valid=%b data=%h required 1 44", tx_valid, tx_data);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({tx_valid, tx_last, busy, done} !== 4'b0000 || raddr !== '0) begin
      errors++; $display("FAIL midrst_abort: valid/last/busy/done=%b raddr=%0d required 0000 0", {tx_valid, tx_last, busy, done}, raddr);
    end
    build_exp(regs);
    run_frame(0, 40, cyc, tmo, bb);
    repeat (2) tick();
    checks++;
    if (tmo || cyc != 11 || frame_errors() != 0) begin
      errors++; $display("FAIL midrst_frame: %0d bad positions, %0d cycles required 0 and 11", frame_errors(), cyc);
    end
  endtask

  task automatic test_random();
    int cyc, bb; bit tmo;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < N; k++) regs[k] = DW'($urandom);
      build_exp(regs);
      run_frame(2, 300, cyc, tmo, bb);
      repeat (2) tick();
      checks++;
      if (tmo || frame_errors() != 0) begin
        errors++; $display("FAIL rand_words[%0d]: %0d bad positions (timeout=%0d) required 0", it, frame_errors(), tmo);
      end
      checks++;
      if (last_errors() != 0 || stall_viol != 0) begin
        errors++; $display("FAIL rand_stream[%0d]: last errs %0d stall errs %0d required 0 0", it, last_errors(), stall_viol);
      end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL rand_done[%0d]: %0d done cycles required 1", it, done_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_restart();
    test_back_to_back();
    test_snapshot();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regs_dump.md
Name: regs_dump

Overview:
- Read-side master for the picoMIPS register file.
- On a start pulse it walks every register through one read port (raddr/rdata) and streams a framed snapshot out on a valid/ready byte interface: header, register contents in address order, then a checksum.
- Used for debug readout and for the testbench scoreboard. It never writes the register file.

Parameters:
- ADDR_WIDTH, 2, register address width; register count N = 2**ADDR_WIDTH (ADDR_WIDTH >= 1).
- DATA_WIDTH, 8, register and stream word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a dump; ignored while busy.
- raddr  out  ADDR_WIDTH  read address driven to the register file read port.
- rdata  in  DATA_WIDTH  register file read data; combinational from raddr.
- tx_data  out  DATA_WIDTH  stream word.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the word; a transfer occurs when tx_valid & tx_ready at a clock edge.
- tx_last  out  1  marks the final word of the frame (checksum).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the checksum transfer.

Behaviour:
- Reset: state=IDLE, index=0, raddr=0, tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0, checksum accumulator=0. Reset mid-frame aborts the frame immediately; there is no partial-frame completion.
- Outputs are registered. raddr equals the internal index register.
- FSM states: IDLE, HDR, FETCH, SEND, CSUM.
- IDLE:
  - start=1 -> HDR.
  - On entry to HDR: tx_data = N mod 2**DATA_WIDTH, tx_valid=1, index=0, checksum=0.
- HDR: hold tx_data/tx_valid until the transfer. On transfer -> FETCH, tx_valid=0.
- FETCH:
  - Exactly one cycle with raddr=index.
  - At the end of the cycle: tx_data<=rdata, checksum<=checksum XOR rdata, tx_valid<=1. Next state SEND.
- SEND: hold the word until the transfer. On transfer:
  - If index == N-1 -> CSUM, with tx_data=checksum, tx_valid=1, tx_last=1.
  - Otherwise index<=index+1 -> FETCH, with tx_valid=0.
- CSUM: on transfer -> IDLE, tx_valid=0, tx_last=0, done=1 for exactly the next cycle.
- AXI-style stream rules:
  - tx_data and tx_last are stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without a transfer except on reset.
  - tx_ready is ignored while tx_valid=0.
- Snapshot semantics: each register is sampled in its own FETCH cycle. Writes to the register file before that cycle are seen; later writes are not. No atomic snapshot across registers.
- Checksum: XOR of the N register words only, not the header.
- The index wraps only by termination at N-1; it never overflows.
- start while busy: ignored, with no queuing.
- start in the same cycle as the final CSUM transfer: ignored. start is accepted only in IDLE.
- done and start may coincide; a start in the done cycle is accepted because state is IDLE.
- Latency with tx_ready held at 1, start sampled at edge t:
  - Header valid in cycle t+1.
  - Register k valid in cycle t+3+2k.
  - Checksum valid in cycle t+2N+2.
  - done in cycle t+2N+3.
  - For N=4: 11 cycles start-to-done.

Test Plan:
- Regs preset to 0x11,0x22,0x44,0x88, tx_ready=1, pulse start -> stream 04,11,22,44,88,FF; tx_last only on FF; raddr sequence 0,1,2,3; done one cycle after FF; 11 cycles total.
- Same preset, tx_ready toggling 1-0-0-1 -> identical word sequence; tx_data and tx_last stable during every stall; no duplicated or dropped word.
- All registers 0x00 -> stream 04,00,00,00,00,00, tx_last on the final 00; busy high from t+1 until done.
- start re-pulsed while in SEND of register 1 -> ignored; exactly one frame; busy low after done; a fresh start then gives a second full frame.
- Write 0x5A into reg 2 before its FETCH and 0xA5 into reg 0 after its FETCH (initial 0x11,0x22,0x44,0x88) -> stream 04,11,22,5A,88, checksum = 11^22^5A^88 = E1.
- reset asserted during SEND of register 2 -> next cycle tx_valid=0, tx_last=0, busy=0, raddr=0, done=0; a subsequent start yields a clean full frame starting with header 04.
